// File: rtl/user_uart_pkg.sv
// user_uart_pkg: shared types and constants for the user-project UART transmitter
//   uart_state_t        transmitter FSM states
//   FRAME_BITS_8N1/8E1  frame lengths without/with the parity bit
//   DEFAULT_CLK_DIV     clk_div for 9600 baud from a 40 MHz clock
package user_uart_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_t;
  localparam int FRAME_BITS_8N1 = 10;
  localparam int FRAME_BITS_8E1 = 11;
  localparam int DEFAULT_CLK_DIV = 4166;
  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction
endpackage

// File: rtl/user_uart_tx_fifo.sv
// user_uart_tx_fifo: synchronous byte FIFO with first-word fall-through read
//   clk, rst      clock, asynchronous active-high reset
//   push, wdata   write strobe and byte (caller guarantees not full)
//   pop, rdata    read strobe (caller guarantees not empty) and head byte
//   level, empty  occupancy and empty flag
module user_uart_tx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [7:0]               wdata,
  input  logic                     pop,
  output logic [7:0]               rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  assign rdata = mem[rd_ptr];
  assign empty = level == '0;
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(push) - LW'(pop);
    end
  end
endmodule

// File: rtl/user_uart_tx.sv
// user_uart_tx: FIFO-buffered 8N1 UART transmitter (8E1 when UART_TX_PARITY_EN is defined)
//   wb_clk_i, wb_rst_i   clock, asynchronous active-high reset
//   enable               allows new frames to start
//   clk_div              bit period minus one, latched per frame
//   in_data/in_valid/in_ready  byte push handshake into the FIFO
//   tx, busy, tx_done    registered serial line, frame-active flag, end-of-stop pulse
//   fifo_level           FIFO occupancy
module user_uart_tx
  import user_uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W = 16
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic                          enable,
  input  logic [DIV_W-1:0]              clk_div,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          tx,
  output logic                          busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  uart_state_t state;
  logic [7:0] fifo_rdata, shift_q;
  logic fifo_empty, pop, bit_end, tx_next;
  logic [DIV_W-1:0] div_q, baud_cnt;
  logic [2:0] bit_idx;
`ifdef UART_TX_PARITY_EN
  logic parity_q;
`endif
  assign in_ready = !wb_rst_i && (fifo_level != LW'(FIFO_DEPTH));
  assign bit_end = baud_cnt == '0;
  // a new frame starts from idle or straight out of the last stop-bit clock
  assign pop = enable && !fifo_empty && (state == ST_IDLE || (state == ST_STOP && bit_end));
  user_uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .push  (in_valid && in_ready),
    .wdata (in_data),
    .pop   (pop),
    .rdata (fifo_rdata),
    .level (fifo_level),
    .empty (fifo_empty)
  );
  always_comb begin
    tx_next = state == ST_START ? 1'b0 :
              state == ST_DATA  ? shift_q[0] :
`ifdef UART_TX_PARITY_EN
              state == ST_PARITY ? parity_q :
`endif
              1'b1;
  end
  // outputs are registered from the current state, so tx trails the FSM by one clock
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state    <= ST_IDLE;
      div_q    <= '0;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift_q  <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      tx_done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      tx      <= tx_next;
      busy    <= state != ST_IDLE;
      tx_done <= state == ST_STOP && bit_end;
      if (pop) begin
        state    <= ST_START;
        div_q    <= clk_div;
        baud_cnt <= clk_div;
        shift_q  <= fifo_rdata;
`ifdef UART_TX_PARITY_EN
        parity_q <= even_parity(fifo_rdata);
`endif
      end else if (state != ST_IDLE) begin
        if (!bit_end) begin
          baud_cnt <= baud_cnt - 1'b1;
        end else begin
          baud_cnt <= div_q;
          case (state)
            ST_START: begin
              state   <= ST_DATA;
              bit_idx <= '0;
            end
            ST_DATA: begin
              shift_q <= shift_q >> 1;
              bit_idx <= bit_idx + 3'd1;
`ifdef UART_TX_PARITY_EN
              if (bit_idx == 3'd7) state <= ST_PARITY;
`else
              if (bit_idx == 3'd7) state <= ST_STOP;
`endif
            end
            ST_PARITY: state <= ST_STOP;
            default: state <= ST_IDLE;
          endcase
        end
      end
    end
  end
endmodule
